// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// values, ALU and branch-condition codes, mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    CL_MEM     = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_IMM     = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_ILLEGAL = 3'd5
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_BGTE  = 6'h01;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BLEQ  = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] BC_EQ = 3'd0;
  localparam logic [2:0] BC_NE = 3'd1;
  localparam logic [2:0] BC_GT = 3'd2;
  localparam logic [2:0] BC_GE = 3'd3;
  localparam logic [2:0] BC_LT = 3'd4;
  localparam logic [2:0] BC_LE = 3'd5;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational instruction classifier with alu_ctl / branch_cond lookup.
// MC_EXT_BRANCH_EN adds bne/bgt/bgte/ble/bleq to the branch class.
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic       is_store_o,
  output logic [2:0] alu_ctl_o,
  output logic [2:0] branch_cond_o,
  output logic       imm_zext_o
);

  // Opcode/funct lookup; anything unmatched falls through as illegal
  always_comb begin
    iclass_o      = CL_ILLEGAL;
    is_store_o    = 1'b0;
    alu_ctl_o     = ALU_ADD;
    branch_cond_o = BC_EQ;
    imm_zext_o    = 1'b0;
    case (op_i)
      OP_LW: iclass_o = CL_MEM;
      OP_SW: begin
        iclass_o   = CL_MEM;
        is_store_o = 1'b1;
      end
      OP_RTYPE: begin
        iclass_o = CL_RTYPE;
        case (funct_i)
          FN_ADD:  alu_ctl_o = ALU_ADD;
          FN_SUB:  alu_ctl_o = ALU_SUB;
          FN_AND:  alu_ctl_o = ALU_AND;
          FN_OR:   alu_ctl_o = ALU_OR;
          FN_SLT:  alu_ctl_o = ALU_SLT;
          default: iclass_o  = CL_ILLEGAL;
        endcase
      end
      OP_BEQ: iclass_o = CL_BRANCH;
`ifdef MC_EXT_BRANCH_EN
      OP_BNE: begin
        iclass_o      = CL_BRANCH;
        branch_cond_o = BC_NE;
      end
      OP_BGT: begin
        iclass_o      = CL_BRANCH;
        branch_cond_o = BC_GT;
      end
      OP_BGTE: begin
        iclass_o      = CL_BRANCH;
        branch_cond_o = BC_GE;
      end
      OP_BLE: begin
        iclass_o      = CL_BRANCH;
        branch_cond_o = BC_LT;
      end
      OP_BLEQ: begin
        iclass_o      = CL_BRANCH;
        branch_cond_o = BC_LE;
      end
`endif
      OP_ADDI: iclass_o = CL_IMM;
      OP_ANDI: begin
        iclass_o   = CL_IMM;
        alu_ctl_o  = ALU_AND;
        imm_zext_o = 1'b1;
      end
      OP_ORI: begin
        iclass_o   = CL_IMM;
        alu_ctl_o  = ALU_OR;
        imm_zext_o = 1'b1;
      end
      OP_SLTI: begin
        iclass_o  = CL_IMM;
        alu_ctl_o = ALU_SLT;
      end
      OP_J:    iclass_o = CL_JUMP;
      default: iclass_o = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM driving the shared-ALU datapath muxes and enables.
// Optional extended branches are enabled by defining MC_EXT_BRANCH_EN.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [2:0]  branch_cond,
  output logic [1:0]  pc_src,
  output logic        ior_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic [2:0]  alu_ctl,
  output logic        illegal,
  output logic [3:0]  state
);

  state_e     state_q, state_d;
  iclass_e    iclass_s;
  logic       is_store_s;
  logic [2:0] dec_alu_s;
  logic [2:0] dec_bc_s;
  logic       dec_zext_s;
  logic       unused_instr_s;

  assign unused_instr_s = ^instr[25:6];

  mc_opdecode u_opdecode (
    .op_i          (instr[31:26]),
    .funct_i       (instr[5:0]),
    .iclass_o      (iclass_s),
    .is_store_o    (is_store_s),
    .alu_ctl_o     (dec_alu_s),
    .branch_cond_o (dec_bc_s),
    .imm_zext_o    (dec_zext_s)
  );

  // Next-state selection; mem_ready only matters in the three memory-wait states
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (iclass_s)
          CL_MEM:    state_d = S_MEMADR;
          CL_RTYPE:  state_d = S_RTYPE_EX;
          CL_IMM:    state_d = S_IMM_EX;
          CL_BRANCH: state_d = S_BRANCH;
          CL_JUMP:   state_d = S_JUMP;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = is_store_s ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset gates every output combinationally so in-flight writes drop immediately
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_cond   = BC_EQ;
    pc_src        = PCSRC_ALU;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    imm_zext      = 1'b0;
    alu_ctl       = ALU_AND;
    illegal       = 1'b0;
    state         = 4'd0;
    if (reset) begin
      state = 4'd0;
    end else begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          alu_ctl   = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = ALUB_BOFS;
          alu_ctl   = ALU_ADD;
          illegal   = (iclass_s == CL_ILLEGAL);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_ctl   = ALU_ADD;
        end
        S_MEMRD: begin
          ior_d    = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          ior_d     = 1'b1;
          mem_write = 1'b1;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_ctl   = dec_alu_s;
        end
        S_RTYPE_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ctl       = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PCSRC_ALUOUT;
          branch_cond   = dec_bc_s;
        end
        S_IMM_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_ctl   = dec_alu_s;
          imm_zext  = dec_zext_s;
        end
        S_IMM_WB: begin
          reg_write = 1'b1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, imm_zext, illegal;
  logic [2:0]  branch_cond, alu_ctl;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  state;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_IMM = 3, K_BR = 4, K_J = 5, K_ILL = 6;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_cond(branch_cond),
    .pc_src(pc_src), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_ctl(alu_ctl), .illegal(illegal), .state(state)
  );

  logic [25:0] obs_s;
  assign obs_s = {state, pc_write, pc_write_cond, branch_cond, pc_src, ior_d, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, imm_zext, alu_ctl, illegal};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%07h expected 0x%07h", tag, got, exp);
  endtask

  // Instruction-level meaning of each opcode/funct
  task automatic ref_decode(input logic [31:0] ins, output int kind, output logic [2:0] alu,
                            output logic [2:0] bc, output logic zext);
    logic [5:0] op, fn;
    bit ext;
`ifdef MC_EXT_BRANCH_EN
    ext = 1'b1;
`else
    ext = 1'b0;
`endif
    op = ins[31:26]; fn = ins[5:0];
    kind = K_ILL; alu = 3'b010; bc = 3'd0; zext = 1'b0;
    if (op == 6'h23) kind = K_LW;
    else if (op == 6'h2B) kind = K_SW;
    else if (op == 6'h00) begin
      kind = K_R;
      if (fn == 6'h20) alu = 3'b010;
      else if (fn == 6'h22) alu = 3'b110;
      else if (fn == 6'h24) alu = 3'b000;
      else if (fn == 6'h25) alu = 3'b001;
      else if (fn == 6'h2A) alu = 3'b111;
      else kind = K_ILL;
    end
    else if (op == 6'h04) kind = K_BR;
    else if (ext && op == 6'h05) begin kind = K_BR; bc = 3'd1; end
    else if (ext && op == 6'h07) begin kind = K_BR; bc = 3'd2; end
    else if (ext && op == 6'h01) begin kind = K_BR; bc = 3'd3; end
    else if (ext && op == 6'h06) begin kind = K_BR; bc = 3'd4; end
    else if (ext && op == 6'h03) begin kind = K_BR; bc = 3'd5; end
    else if (op == 6'h08) kind = K_IMM;
    else if (op == 6'h0C) begin kind = K_IMM; alu = 3'b000; zext = 1'b1; end
    else if (op == 6'h0D) begin kind = K_IMM; alu = 3'b001; zext = 1'b1; end
    else if (op == 6'h0A) begin kind = K_IMM; alu = 3'b111; end
    else if (op == 6'h02) kind = K_J;
  endtask

  // Expected output vector for one cycle spent in datapath step st
  function automatic logic [25:0] exp_vec(input int st, input int kind, input logic [2:0] alu,
                                          input logic [2:0] bc, input logic zext, input logic rdy);
    logic pw = 0, pwc = 0, ior = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic iz = 0, ill = 0;
    logic [2:0] bcx = 3'd0, ac = 3'b000;
    logic [1:0] ps = 2'b00, sb = 2'b00;
    if (st == 0) begin mr = 1; sb = 2'b01; ac = 3'b010; irw = rdy; pw = rdy; end
    if (st == 1) begin sb = 2'b11; ac = 3'b010; ill = (kind == K_ILL); end
    if (st == 2) begin sa = 1; sb = 2'b10; ac = 3'b010; end
    if (st == 3) begin ior = 1; mr = 1; end
    if (st == 4) begin m2r = 1; rw = 1; end
    if (st == 5) begin ior = 1; mw = 1; end
    if (st == 6) begin sa = 1; ac = alu; end
    if (st == 7) begin rd = 1; rw = 1; end
    if (st == 8) begin sa = 1; ac = 3'b110; pwc = 1; ps = 2'b01; bcx = bc; end
    if (st == 9) begin sa = 1; sb = 2'b10; ac = alu; iz = zext; end
    if (st == 10) rw = 1;
    if (st == 11) begin pw = 1; ps = 2'b10; end
    return {st[3:0], pw, pwc, bcx, ps, ior, mr, mw, irw, rd, m2r, rw, sa, sb, iz, ac, ill};
  endfunction

  function automatic void build_steps(input int kind, output int steps[$]);
    steps = {0, 1};
    case (kind)
      K_LW:    steps = {0, 1, 2, 3, 4};
      K_SW:    steps = {0, 1, 2, 5};
      K_R:     steps = {0, 1, 6, 7};
      K_IMM:   steps = {0, 1, 9, 10};
      K_BR:    steps = {0, 1, 8};
      K_J:     steps = {0, 1, 11};
      default: steps = {0, 1};
    endcase
  endfunction

  // Called at posedge+1 with the DUT expected in FETCH; walks one whole instruction
  task automatic run_instr(input logic [31:0] ins);
    int kind; logic [2:0] alu, bc; logic zext, rdy; int steps[$]; int waits; bit wst;
    ref_decode(ins, kind, alu, bc, zext);
    build_steps(kind, steps);
    instr = ins;
    foreach (steps[i]) begin
      waits = 0;
      wst = (steps[i] == 0) || (steps[i] == 3) || (steps[i] == 5);
      do begin
        if (wst) rdy = (waits >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
        else     rdy = $urandom_range(0, 1) != 0;
        mem_ready = rdy;
        @(negedge clk);
        check_val($sformatf("st%0d_ins%08h", steps[i], ins), {6'd0, obs_s},
                  {6'd0, exp_vec(steps[i], kind, alu, bc, zext, rdy)});
        @(posedge clk); #1;
        waits++;
      end while (wst && !rdy);
    end
  endtask

  // Advance n_pre zero-wait steps, then assert reset inside the following step
  task automatic reset_in(input logic [31:0] ins, input int n_pre);
    int kind; logic [2:0] alu, bc; logic zext; int steps[$];
    ref_decode(ins, kind, alu, bc, zext);
    build_steps(kind, steps);
    instr = ins;
    mem_ready = 1'b1;
    repeat (n_pre) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check_val($sformatf("pre_rst_st%0d", steps[n_pre]), {6'd0, obs_s},
              {6'd0, exp_vec(steps[n_pre], kind, alu, bc, zext, 1'b0)});
    #1 reset = 1'b1;
    #1 check_val("rst_same_cycle", {6'd0, obs_s}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("fetch_after_rst", {6'd0, obs_s}, {6'd0, exp_vec(0, K_ILL, 3'd0, 3'd0, 1'b0, 1'b0)});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [15];
    logic [5:0] fns [6];
    logic [31:0] r;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h07, 6'h01,
            6'h06, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[31:26] = ops[$urandom_range(0, 14)];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 5)];
    return r;
  endfunction

  initial begin
    logic [31:0] directed [12];
    directed = '{32'h8C820004, 32'hAC820004, 32'h00851020, 32'h0085102A, 32'h00851022,
                 32'h10850003, 32'h1C850002, 32'h34A2FFFF, 32'h08000010, 32'hFC000000,
                 32'h3085000F, 32'h14850001};
    reset = 1'b1; mem_ready = 1'b1; instr = 32'h8C820004;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", {6'd0, obs_s}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (directed[i]) run_instr(directed[i]);
    reset_in(32'h8C820004, 3);
    reset_in(32'hAC820004, 3);
    reset_in(32'h00851020, 3);
    repeat (150) run_instr(rand_instr());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS control unit. Sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback. One instruction takes 3–5 cycles plus memory wait states. Sits between the instruction register and the datapath muxes/enables, and replaces per-instruction single-cycle decode in the multicycle core.

## Interface
Parameters:
- none (encodings fixed in `mc_pkg`)

Ports:
- `clk` in 1 — rising-edge clock; single clock domain
- `reset` in 1 — synchronous, active-high
- `instr` in 32 — instruction register contents; valid from DECODE onward
- `mem_ready` in 1 — memory completes the current read/write this cycle
- `pc_write` out 1 — unconditional PC load
- `pc_write_cond` out 1 — PC load if datapath branch condition true
- `branch_cond` out 3 — 0 eq, 1 ne, 2 gt, 3 ge, 4 lt, 5 le (rs vs rt, signed)
- `pc_src` out 2 — 00 ALU result, 01 ALUOut, 10 jump target
- `ior_d` out 1 — memory address: 0 PC, 1 ALUOut
- `mem_read` out 1 — memory read request
- `mem_write` out 1 — memory write request
- `ir_write` out 1 — IR load
- `reg_dst` out 1 — 1 rd, 0 rt
- `mem_to_reg` out 1 — 1 MDR, 0 ALUOut
- `reg_write` out 1 — register file write
- `alu_src_a` out 1 — 0 PC, 1 A
- `alu_src_b` out 2 — 00 B, 01 const 4, 10 imm, 11 sign-ext imm<<2
- `imm_zext` out 1 — immediate zero-extended (andi/ori)
- `alu_ctl` out 3 — 010 add, 110 sub, 000 and, 001 or, 111 slt
- `illegal` out 1 — one-cycle pulse on unsupported opcode/funct
- `state` out 4 — current state, for debug

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BRANCH 8, IMM_EX 9, IMM_WB 10, JUMP 11. Unlisted outputs are 0.
- FETCH:
  - `mem_read`=1, `ior_d`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00.
  - `ir_write` and `pc_write` = `mem_ready`.
  - Holds until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target into ALUOut). Dispatch:
  - lw (0x23) / sw (0x2B) → MEMADR
  - opcode 0 with funct 0x20/22/24/25/2A → RTYPE_EX
  - beq 0x04 → BRANCH
  - addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A → IMM_EX
  - j 0x02 → JUMP
  - anything else → `illegal`=1, next FETCH (instruction skipped; PC already advanced)
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: `ior_d`=1, `mem_read`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1. Next FETCH.
- MEMWR: `ior_d`=1, `mem_write`=1. Holds until `mem_ready`, then FETCH.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_ctl` from funct (add/sub/and/or/slt). Next RTYPE_WB.
- RTYPE_WB: `reg_dst`=1, `reg_write`=1. Next FETCH.
- IMM_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_ctl` add/and/or/slt per opcode; `imm_zext`=1 for andi/ori. Next IMM_WB.
- IMM_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1. Next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_write_cond`=1, `pc_src`=01, `branch_cond` per opcode. Next FETCH.
- JUMP: `pc_write`=1, `pc_src`=10. Next FETCH.
- Opcode/funct are sampled from `instr` in each state. The IR is stable because `ir_write` is only asserted in FETCH.

## Timing
- All outputs are a function of registered state plus `instr`/`mem_ready`.
- While `reset`=1, all outputs are forced to 0 and `state` reads 0. The state register loads FETCH on any edge with `reset`=1, so the first fetch request is in the first cycle after deassertion.
- Reset mid-operation: the pending `mem_write`/`reg_write` drops in the same cycle; the partial instruction is abandoned.
- Zero-wait latency: lw 5 cycles, sw 4, R-type 4, imm 4, branch 3, jump 3. Each `mem_ready`=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- `mem_ready` is ignored outside FETCH/MEMRD/MEMWR.
- `mem_read` and `mem_write` are never both 1.
- `illegal` is high for exactly one cycle per bad instruction.

## Configuration
- `MC_EXT_BRANCH_EN` defined: bne 0x05 (ne), bgt 0x07 (gt), bgte 0x01 (ge), ble 0x06 (lt), bleq 0x03 (le) dispatch to BRANCH with the listed `branch_cond`.
- Undefined: only beq reaches BRANCH; the other five opcodes raise `illegal`.

## Structure
- `mc_pkg`: state enum, opcode and funct constants, `alu_ctl` codes, `branch_cond` codes, `alu_src_b`/`pc_src` codes.
- Sub-module `mc_opdecode`: combinational instruction-class classifier (mem, rtype, imm, branch, jump, illegal) plus `alu_ctl`/`branch_cond` lookup. Used by DECODE and the execute states.

## Test plan
- Reset for 2 cycles, then `instr`=0x8C820004 (lw), `mem_ready`=1 → states 0,1,2,3,4,0. `reg_write`=1 only in state 4, with `mem_to_reg`=1.
- sw 0xAC820004, `mem_ready` low for 3 cycles in MEMWR → `mem_write` high 4 cycles, then FETCH; `reg_write` never asserted.
- add 0x00851020 → RTYPE_EX with `alu_ctl`=010, then RTYPE_WB with `reg_dst`=1, `reg_write`=1. Repeat with funct 0x2A → `alu_ctl`=111.
- beq 0x10850003 → BRANCH with `pc_write_cond`=1, `branch_cond`=0. bgt 0x1C850002: `branch_cond`=2 with macro defined; with macro undefined, `illegal` pulses in DECODE, next state FETCH.
- ori 0x34A2FFFF → IMM_EX with `alu_ctl`=001, `imm_zext`=1. j 0x08000010 → JUMP with `pc_write`=1, `pc_src`=10.
- Illegal opcode 0xFC000000 → one-cycle `illegal`, no writes. Reset asserted during MEMRD → outputs 0 same cycle, FETCH after release.
